// File: rtl/bist_misr16_pkg.sv
// BIST shared definitions: MISR width, feedback taps, seed, FSM states.
// Common to the pattern generator and the response compactor.
package bist_misr16_pkg;

  localparam int          BIST_W       = 16;
  localparam int          BIST_CNT_W   = 16;
  localparam logic [15:0] BIST_TAPMASK = 16'h8210;
  localparam logic [15:0] BIST_SEED    = 16'h0000;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } bist_state_e;

  typedef logic [BIST_CNT_W-1:0] bist_cnt_t;

endpackage

// File: rtl/bist_misr16_if.sv
// Control/response bundle between a BIST controller and the MISR.
// master drives requests and responses; slave is the compactor.
interface bist_misr16_if
  import bist_misr16_pkg::*;
#(
  parameter int WIDTH = BIST_W
) ();

  logic             start;
  bist_cnt_t        pattern_count;
  logic [WIDTH-1:0] golden;
  logic [WIDTH-1:0] resp;
  logic             resp_valid;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] signature;
  logic             pass;

  modport master (
    output start,
    output pattern_count,
    output golden,
    output resp,
    output resp_valid,
    input  busy,
    input  done,
    input  signature,
    input  pass
  );

  modport slave (
    input  start,
    input  pattern_count,
    input  golden,
    input  resp,
    input  resp_valid,
    output busy,
    output done,
    output signature,
    output pass
  );

endinterface

// File: rtl/bist_misr16_misr_step.sv
// One MISR compaction step: rotate left, fold taps on the old MSB,
// then absorb the response word.
module misr_step #(
  parameter int               WIDTH   = 16,
  parameter logic [WIDTH-1:0] TAPMASK = 16'h8210
) (
  input  logic [WIDTH-1:0] sig,
  input  logic [WIDTH-1:0] resp,
  output logic [WIDTH-1:0] sig_next
);

  logic [WIDTH-1:0] rot;
  logic [WIDTH-1:0] fb;

  always_comb begin
    rot      = {sig[WIDTH-2:0], sig[WIDTH-1]};
    fb       = sig[WIDTH-1] ? TAPMASK : '0;
    sig_next = rot ^ fb ^ resp;
  end

endmodule

// File: rtl/bist_misr16.sv
// BIST response compactor: run-length counter and IDLE/RUN/DONE
// control around a 16-bit MISR, with golden signature compare.
module bist_misr16
  import bist_misr16_pkg::*;
#(
  parameter int               WIDTH   = BIST_W,
  parameter logic [WIDTH-1:0] TAPMASK = BIST_TAPMASK,
  parameter logic [WIDTH-1:0] SEED    = BIST_SEED
) (
  input  logic                clk,
  input  logic                rst,
  bist_misr16_if.slave        bus
);

  bist_state_e      state_q, state_d;
  logic [WIDTH-1:0] sig_q, sig_d;
  bist_cnt_t        rem_q, rem_d;
  logic [WIDTH-1:0] sig_nxt;

  misr_step #(
    .WIDTH   (WIDTH),
    .TAPMASK (TAPMASK)
  ) u_step (
    .sig      (sig_q),
    .resp     (bus.resp),
    .sig_next (sig_nxt)
  );

  always_comb begin
    state_d = state_q;
    sig_d   = sig_q;
    rem_d   = rem_q;
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (bus.start) begin
          sig_d   = SEED;
          rem_d   = bus.pattern_count;
          state_d = (bus.pattern_count == '0) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        // start is deliberately ignored here; only valid responses advance
        if (bus.resp_valid) begin
          sig_d = sig_nxt;
          rem_d = rem_q - 1'b1;
          if (rem_q == bist_cnt_t'(1)) begin
            state_d = ST_DONE;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      sig_q   <= SEED;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      sig_q   <= sig_d;
      rem_q   <= rem_d;
    end
  end

  always_comb begin
    bus.busy      = (state_q == ST_RUN);
    bus.done      = (state_q == ST_DONE);
    bus.signature = sig_q;
    bus.pass      = (state_q == ST_DONE) && (sig_q == bus.golden);
  end

endmodule

// File: tb/tb_bist_misr16.sv
// Directed and randomized checks of bist_misr16 against a
// queue-based signature reference model.
module tb_bist_misr16;

  localparam logic [15:0] TAP  = 16'h8210;
  localparam logic [15:0] SEED = 16'h0000;

  logic clk;
  logic rst;
  int   vectors;
  int   errs;

  logic [15:0] q[$];

  bist_misr16_if bus ();

  bist_misr16 u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] mstep(logic [15:0] s, logic [15:0] r);
    int unsigned v;
    v = {16'h0, s};
    v = ((v << 1) | (v >> 15)) & 32'hFFFF;
    if (s >= 16'h8000) v = v ^ {16'h0, TAP};
    return v[15:0] ^ r;
  endfunction

  function automatic logic [15:0] fold(logic [15:0] seed, logic [15:0] rs[$]);
    logic [15:0] s;
    s = seed;
    foreach (rs[i]) s = mstep(s, rs[i]);
    return s;
  endfunction

  task automatic chk16(string tag, logic [15:0] obs, logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(string tag, logic obs, logic exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(logic [15:0] pc);
    bus.start         = 1'b1;
    bus.pattern_count = pc;
    tick();
    bus.start = 1'b0;
    q.delete();
  endtask

  task automatic give(logic [15:0] r);
    bus.resp       = r;
    bus.resp_valid = 1'b1;
    tick();
    bus.resp_valid = 1'b0;
    q.push_back(r);
  endtask

  initial begin
    logic [15:0] s;
    logic [15:0] pc;
    logic [15:0] hold;
    int          guard;
    vectors = 0;
    errs    = 0;

    rst               = 1'b1;
    bus.start         = 1'b0;
    bus.pattern_count = '0;
    bus.golden        = '0;
    bus.resp          = '0;
    bus.resp_valid    = 1'b0;
    #2;
    chk1("rst_busy", bus.busy, 1'b0);
    chk1("rst_done", bus.done, 1'b0);
    chk1("rst_pass", bus.pass, 1'b0);
    chk16("rst_sig", bus.signature, SEED);
    tick();
    rst = 1'b0;

    // valid in IDLE is ignored
    give(16'hBEEF);
    chk16("idle_hold", bus.signature, SEED);
    chk1("idle_done", bus.done, 1'b0);

    // single compaction
    do_start(16'd1);
    chk1("pc1_busy", bus.busy, 1'b1);
    give(16'h0001);
    chk1("pc1_done", bus.done, 1'b1);
    chk1("pc1_busy0", bus.busy, 1'b0);
    chk16("pc1_sig", bus.signature, 16'h0001);
    bus.golden = 16'h0001;
    #1;
    chk1("pc1_pass", bus.pass, 1'b1);
    bus.golden = 16'h0002;
    #1;
    chk1("pc1_nopass", bus.pass, 1'b0);

    // valid in DONE is ignored
    give(16'h1234);
    chk16("done_hold", bus.signature, 16'h0001);
    chk1("done_hold_d", bus.done, 1'b1);

    // feedback taps
    do_start(16'd2);
    give(16'h8000);
    chk1("pc2_busy", bus.busy, 1'b1);
    give(16'h0000);
    chk16("pc2_sig", bus.signature, 16'h8211);
    chk1("pc2_done", bus.done, 1'b1);

    // stalls
    do_start(16'd3);
    bus.resp = 16'h0000;
    for (int i = 0; i < 6; i++) begin
      bus.resp_valid = (i == 0 || i == 3 || i == 5);
      tick();
      if (i < 5) begin
        chk1("stall_busy", bus.busy, 1'b1);
        chk1("stall_done", bus.done, 1'b0);
      end
    end
    bus.resp_valid = 1'b0;
    chk1("stall_fin", bus.done, 1'b1);
    chk16("stall_sig", bus.signature, 16'h0000);

    // zero-length run
    give(16'h5555);
    do_start(16'd0);
    chk1("pc0_done", bus.done, 1'b1);
    chk16("pc0_sig", bus.signature, SEED);
    bus.golden = 16'h0000;
    #1;
    chk1("pc0_pass", bus.pass, 1'b1);

    // start during RUN ignored
    do_start(16'd4);
    give(16'hA5A5);
    bus.start         = 1'b1;
    bus.pattern_count = 16'd9;
    give(16'h0F0F);
    bus.start = 1'b0;
    give(16'h1111);
    chk1("rerun_busy", bus.busy, 1'b1);
    give(16'hC3C3);
    chk1("rerun_done", bus.done, 1'b1);
    chk16("rerun_sig", bus.signature, fold(SEED, q));

    // reset mid-run
    do_start(16'd10);
    for (int i = 0; i < 3; i++) give(16'($urandom));
    rst = 1'b1;
    #1;
    chk1("arst_busy", bus.busy, 1'b0);
    chk1("arst_done", bus.done, 1'b0);
    chk16("arst_sig", bus.signature, 16'h0000);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) give(16'($urandom));
    chk1("arst_idle", bus.busy, 1'b0);
    chk1("arst_nodone", bus.done, 1'b0);
    do_start(16'd10);
    for (int i = 0; i < 10; i++) begin
      chk1("full10_busy", bus.busy, 1'b1);
      give(16'($urandom));
    end
    chk1("full10_done", bus.done, 1'b1);
    chk16("full10_sig", bus.signature, fold(SEED, q));

    // randomized runs with stalls and spurious starts
    for (int k = 0; k < 10; k++) begin
      pc = 16'($urandom_range(1, 12));
      do_start(pc);
      guard = 0;
      while (q.size() < int'(pc) && guard < 200) begin
        bus.resp       = 16'($urandom);
        bus.resp_valid = 1'($urandom);
        bus.start      = ($urandom_range(0, 7) == 0);
        bus.pattern_count = 16'($urandom);
        tick();
        if (bus.resp_valid) q.push_back(bus.resp);
        bus.start = 1'b0;
        chk16("rnd_sig", bus.signature, fold(SEED, q));
        chk1("rnd_busy", bus.busy, q.size() < int'(pc));
        chk1("rnd_done", bus.done, q.size() == int'(pc));
        guard++;
      end
      bus.resp_valid = 1'b0;
      chk1("rnd_bound", guard < 200, 1'b1);
      s = fold(SEED, q);
      bus.golden = ($urandom_range(0, 1) == 1) ? s : s ^ 16'h0100;
      #1;
      chk1("rnd_pass", bus.pass, bus.golden == s);
    end

    // maximum count, no wrap
    bus.start         = 1'b1;
    bus.pattern_count = 16'hFFFF;
    tick();
    bus.start      = 1'b0;
    bus.resp_valid = 1'b1;
    s = SEED;
    for (int i = 0; i < 65534; i++) begin
      bus.resp = 16'($urandom);
      hold     = bus.resp;
      tick();
      s = mstep(s, hold);
    end
    chk1("max_busy", bus.busy, 1'b1);
    chk1("max_notdone", bus.done, 1'b0);
    chk16("max_sig_mid", bus.signature, s);
    bus.resp = 16'($urandom);
    hold     = bus.resp;
    tick();
    bus.resp_valid = 1'b0;
    s = mstep(s, hold);
    chk1("max_done", bus.done, 1'b1);
    chk16("max_sig", bus.signature, s);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
